horner_sequencer: RTL

- Control-side FSM that drives the Horner polynomial datapath (adder and multiplier units with valid/done handshakes).
- Evaluates p(x) = c_N*x^N + … + c_0 as: acc = c_N; then for k = N-1 down to 0, acc = acc*x + c_k.
- Sequences each step's coefficient index, pulses the unit valids and waits for their dones.
- Issues the result load, then reports completion, or an error if a unit stalls.

---
 rtl/horner_sequencer.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/horner_sequencer.sv
// Control FSM for a Horner polynomial datapath: sequences coefficient indices,
// launches the adder and multiplier, watches for stalls and signals completion.
module horner_sequencer #(
   parameter int MAX_ORDER = 8,
   parameter int ORDER_W   = $clog2(MAX_ORDER + 1),
   parameter int TIMEOUT   = 64
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic               start_i,
   input  logic               abort_i,
   input  logic [ORDER_W-1:0] order_i,
   output logic [ORDER_W-1:0] coeff_idx_o,
   output logic               init_o,
   output logic               add_valid_o,
   input  logic               add_done_i,
   output logic               mul_valid_o,
   input  logic               mul_done_i,
   output logic               load_result_o,
   output logic               busy_o,
   output logic               done_o,
   output logic               error_o,
   output logic [3:0]         state_o
);

   localparam int WD_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [WD_W-1:0]    WD_LAST = WD_W'(TIMEOUT - 1);
   localparam logic [ORDER_W-1:0] MAX_N   = ORDER_W'(MAX_ORDER);

   // IDLE is encoded as zero so the debug view reads 0 out of reset.
   typedef enum logic [3:0] {
      S_IDLE      = 4'd0,
      S_SETUP_ADD = 4'd1,
      S_ISSUE_ADD = 4'd2,
      S_WAIT_ADD  = 4'd3,
      S_SETUP_MUL = 4'd4,
      S_ISSUE_MUL = 4'd5,
      S_WAIT_MUL  = 4'd6,
      S_FINISH    = 4'd7,
      S_DONE      = 4'd8,
      S_ERR       = 4'd9
   } state_t;

   state_t          state;
   logic [WD_W-1:0] wd;

   assign state_o = state;

   // Unit handshake: a valid is a one-cycle launch pulse; the unit answers
   // with done (one or more cycles later), which is only honoured in WAIT.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state         <= S_IDLE;
         wd            <= '0;
         coeff_idx_o   <= '0;
         init_o        <= 1'b0;
         add_valid_o   <= 1'b0;
         mul_valid_o   <= 1'b0;
         load_result_o <= 1'b0;
         busy_o        <= 1'b0;
         done_o        <= 1'b0;
         error_o       <= 1'b0;
      end else begin
         add_valid_o   <= 1'b0;
         mul_valid_o   <= 1'b0;
         load_result_o <= 1'b0;
         done_o        <= 1'b0;
         if (abort_i) begin
            state   <= S_IDLE;
            wd      <= '0;
            init_o  <= 1'b0;
            busy_o  <= 1'b0;
            error_o <= 1'b0;
         end else begin
            case (state)
               S_IDLE, S_ERR: begin
                  if (start_i) begin
                     if (order_i > MAX_N) begin
                        state   <= S_ERR;
                        busy_o  <= 1'b0;
                        error_o <= 1'b1;
                     end else begin
                        state       <= S_SETUP_ADD;
                        coeff_idx_o <= order_i;
                        init_o      <= 1'b1;
                        busy_o      <= 1'b1;
                        error_o     <= 1'b0;
                     end
                  end
               end
               S_SETUP_ADD: begin
                  state       <= S_ISSUE_ADD;
                  add_valid_o <= 1'b1;
               end
               S_ISSUE_ADD: begin
                  state <= S_WAIT_ADD;
                  wd    <= '0;
               end
               S_WAIT_ADD: begin
                  if (add_done_i) begin
                     init_o <= 1'b0;
                     wd     <= '0;
                     if (coeff_idx_o == '0) begin
                        state         <= S_FINISH;
                        load_result_o <= 1'b1;
                     end else begin
                        state <= S_SETUP_MUL;
                     end
                  end else if (wd == WD_LAST) begin
                     state   <= S_ERR;
                     wd      <= '0;
                     init_o  <= 1'b0;
                     busy_o  <= 1'b0;
                     error_o <= 1'b1;
                  end else begin
                     wd <= wd + WD_W'(1);
                  end
               end
               S_SETUP_MUL: begin
                  state       <= S_ISSUE_MUL;
                  mul_valid_o <= 1'b1;
               end
               S_ISSUE_MUL: begin
                  state <= S_WAIT_MUL;
                  wd    <= '0;
               end
               S_WAIT_MUL: begin
                  // Index only moves after the multiply, so it holds across each step.
                  if (mul_done_i) begin
                     state       <= S_SETUP_ADD;
                     wd          <= '0;
                     coeff_idx_o <= coeff_idx_o - ORDER_W'(1);
                  end else if (wd == WD_LAST) begin
                     state   <= S_ERR;
                     wd      <= '0;
                     init_o  <= 1'b0;
                     busy_o  <= 1'b0;
                     error_o <= 1'b1;
                  end else begin
                     wd <= wd + WD_W'(1);
                  end
               end
               S_FINISH: begin
                  state  <= S_DONE;
                  done_o <= 1'b1;
               end
               S_DONE: begin
                  state  <= S_IDLE;
                  busy_o <= 1'b0;
               end
               default: begin
                  state  <= S_IDLE;
                  busy_o <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule
